// File: rtl/i2c_slave_ctrl_mp_if.sv
// Bus bundle between the I2C slave sequencer and its edge detectors, shifters and FIFOs.
interface i2c_slave_ctrl_mp_if #(
  parameter int NUM_ADDR  = 2,
  parameter int MAX_BYTES = 16,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1),
  parameter int AW        = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
);
  logic                start_found;
  logic                stop_found;
  logic                byte_received;
  logic                ack_prep;
  logic                check_ack;
  logic                ack_done;
  logic                rw_mode;
  logic [NUM_ADDR-1:0] address_match;
  logic [7:0]          rx_byte;
  logic                sda_in;
  logic                rx_fifo_full;
  logic                rx_enable;
  logic                tx_enable;
  logic                load_data;
  logic                read_enable;
  logic                write_enable;
  logic [1:0]          sda_mode;
  logic [AW-1:0]       addr_sel;
  logic                general_call;
  logic [CNT_W-1:0]    byte_count;
  logic                busy;
  logic                xfer_done;

  modport slave (
    input  start_found, stop_found, byte_received, ack_prep, check_ack, ack_done,
           rw_mode, address_match, rx_byte, sda_in, rx_fifo_full,
    output rx_enable, tx_enable, load_data, read_enable, write_enable, sda_mode,
           addr_sel, general_call, byte_count, busy, xfer_done
  );

  modport master (
    output start_found, stop_found, byte_received, ack_prep, check_ack, ack_done,
           rw_mode, address_match, rx_byte, sda_in, rx_fifo_full,
    input  rx_enable, tx_enable, load_data, read_enable, write_enable, sda_mode,
           addr_sel, general_call, byte_count, busy, xfer_done
  );
endinterface

// File: rtl/i2c_slave_ctrl_mp.sv
// I2C slave transaction sequencer: address check, ACK/NACK, multi-byte read and write.
// Define GENERAL_CALL_EN to also accept the general-call write address 8'h00.
module i2c_slave_ctrl_mp #(
  parameter int NUM_ADDR  = 2,
  parameter int MAX_BYTES = 16,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1),
  parameter int AW        = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
  input logic                clk,
  input logic                rst,
  i2c_slave_ctrl_mp_if.slave bus
);

`ifdef GENERAL_CALL_EN
  localparam bit GcEn = 1'b1;
`else
  localparam bit GcEn = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BYTES);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,  ADDR     = 4'd1,  CHK_ADDR = 4'd2,  DO_NACK = 4'd3,
    DO_ACK    = 4'd4,  LOAD     = 4'd5,  SEND_BYTE = 4'd6, ACK_CHK = 4'd7,
    WAIT      = 4'd8,  WAIT2    = 4'd9,  RX_BYTE  = 4'd10, RX_CHK  = 4'd11,
    RX_STORE  = 4'd12, RX_ACK   = 4'd13, RX_NACK  = 4'd14
  } state_e;

  state_e           state_q, state_d;
  logic             rw_q, rw_d;
  logic [AW-1:0]    sel_q, sel_d;
  logic             gc_q, gc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer_q, xfer_d;
  logic [AW-1:0]    lowest;
  logic             gc_hit, addr_hit;
  logic             rx_en, tx_en, ld, rd, wr;
  logic [1:0]       sda;

  // Highest index first so the lowest matching slot wins.
  always_comb begin
    lowest = '0;
    for (int i = NUM_ADDR - 1; i >= 0; i--) begin
      lowest = bus.address_match[i] ? AW'(i) : lowest;
    end
  end

  assign gc_hit   = GcEn && (bus.rx_byte == 8'h00) && !bus.rw_mode;
  assign addr_hit = (|bus.address_match) || gc_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = bus.start_found   ? ADDR : IDLE;
      ADDR:      state_d = bus.byte_received ? CHK_ADDR : ADDR;
      CHK_ADDR:  if (bus.ack_prep) state_d = addr_hit ? DO_ACK : DO_NACK;
                 else state_d = CHK_ADDR;
      DO_NACK:   state_d = bus.ack_done ? IDLE : DO_NACK;
      DO_ACK:    if (bus.ack_done) state_d = rw_q ? LOAD : RX_BYTE;
                 else state_d = DO_ACK;
      LOAD:      state_d = SEND_BYTE;
      SEND_BYTE: state_d = bus.ack_prep  ? ACK_CHK : SEND_BYTE;
      ACK_CHK:   state_d = bus.check_ack ? WAIT : ACK_CHK;
      WAIT:      state_d = (!bus.sda_in && (cnt_q < MaxCnt)) ? WAIT2 : IDLE;
      WAIT2:     state_d = bus.ack_done ? LOAD : WAIT2;
      RX_BYTE:   state_d = bus.byte_received ? RX_CHK : RX_BYTE;
      RX_CHK:    if (bus.ack_prep) state_d = (bus.rx_fifo_full || cnt_q == MaxCnt) ? RX_NACK : RX_STORE;
                 else state_d = RX_CHK;
      RX_STORE:  state_d = RX_ACK;
      RX_ACK:    state_d = bus.ack_done ? RX_BYTE : RX_ACK;
      RX_NACK:   state_d = bus.ack_done ? IDLE : RX_NACK;
      default:   state_d = IDLE;
    endcase
    // Bus conditions pre-empt the normal sequence once a transfer is under way.
    if (state_q != IDLE && bus.stop_found) begin
      state_d = IDLE;
    end else if (state_q != IDLE && bus.start_found) begin
      state_d = ADDR;
    end else begin
      state_d = state_d;
    end
  end

  always_comb begin
    rw_d  = rw_q;
    sel_d = sel_q;
    gc_d  = gc_q;
    cnt_d = cnt_q;
    if (state_d == ADDR) begin
      rw_d  = 1'b0;
      sel_d = '0;
      gc_d  = 1'b0;
      cnt_d = '0;
    end else if (state_q == CHK_ADDR && state_d == DO_ACK) begin
      rw_d  = bus.rw_mode;
      sel_d = gc_hit ? '0 : lowest;
      gc_d  = gc_hit;
    end else if ((state_q == LOAD || state_q == RX_STORE) && cnt_q != MaxCnt) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    xfer_d = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      sel_q   <= '0;
      gc_q    <= 1'b0;
      cnt_q   <= '0;
      xfer_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      sel_q   <= sel_d;
      gc_q    <= gc_d;
      cnt_q   <= cnt_d;
      xfer_q  <= xfer_d;
    end
  end

  always_comb begin
    rx_en = 1'b0;
    tx_en = 1'b0;
    ld    = 1'b0;
    rd    = 1'b0;
    wr    = 1'b0;
    sda   = 2'b00;
    case (state_q)
      ADDR, RX_BYTE:   rx_en = 1'b1;
      DO_NACK, RX_NACK: sda  = 2'b10;
      DO_ACK, RX_ACK:  sda   = 2'b01;
      LOAD:            begin ld = 1'b1; sda = 2'b11; end
      SEND_BYTE:       begin tx_en = 1'b1; sda = 2'b11; end
      WAIT:            rd = 1'b1;
      RX_STORE:        wr = 1'b1;
      default:         sda = 2'b00;
    endcase
  end

  assign bus.rx_enable    = rx_en;
  assign bus.tx_enable    = tx_en;
  assign bus.load_data    = ld;
  assign bus.read_enable  = rd;
  assign bus.write_enable = wr;
  assign bus.sda_mode     = sda;
  assign bus.addr_sel     = sel_q;
  assign bus.general_call = gc_q;
  assign bus.byte_count   = cnt_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.xfer_done    = xfer_q;

endmodule
